// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one I2C sender among NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to add the S_WAIT watchdog and the sticky o_timeout flag.
module i2c_cmd_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DAT_W       = 24,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*DAT_W-1:0] i_dat,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_busy,
    output logic                     o_start,
    output logic [DAT_W-1:0]         o_dat,
    input  logic                     i_finished,
    output logic                     o_timeout
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("i2c_cmd_arbiter: unsupported parameter values");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n, owner, owner_n, win;
    logic [NUM_REQ-1:0] gnt_n, done_n;
    logic [DAT_W-1:0]   dat_n;
    logic               start_n, fin, expire;

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        logic [IDX_W-1:0] idx;
        win = ptr;
        idx = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (i_req[idx]) win = idx;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        dat_n   = o_dat;
        gnt_n   = '0;
        done_n  = '0;
        start_n = 1'b0;
        fin     = 1'b0;
        case (state)
            S_IDLE: begin
                if (|i_req) begin
                    state_n = S_START;
                    owner_n = win;
                    dat_n   = i_dat[win*DAT_W +: DAT_W];
                    gnt_n   = NUM_REQ'(1) << win;
                    start_n = 1'b1;
                end
            end
            S_START: state_n = S_WAIT;
            S_WAIT:  fin = i_finished | expire;
            default: state_n = S_IDLE;
        endcase
        if (fin) begin
            state_n = S_IDLE;
            done_n  = NUM_REQ'(1) << owner;
            ptr_n   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            owner   <= '0;
            o_dat   <= '0;
            o_gnt   <= '0;
            o_done  <= '0;
            o_start <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            o_dat   <= dat_n;
            o_gnt   <= gnt_n;
            o_done  <= done_n;
            o_start <= start_n;
            o_busy  <= state_n != S_IDLE;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    // Fires on the last allowed S_WAIT cycle so o_done lands TIMEOUT_CYC cycles after entry.
    assign expire = state == S_WAIT && cnt == CNT_W'(TIMEOUT_CYC - 1);

    always_ff @(posedge i_clk) begin
        if (i_rst || state == S_START) cnt <= '0;
        else if (state == S_WAIT) cnt <= cnt + 1'b1;
        if (i_rst) o_timeout <= 1'b0;
        else if (expire && !i_finished) o_timeout <= 1'b1;
    end
`else
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif
endmodule
